// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;
    logic           fits_s;

    // Partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
    always_comb begin
        shifted_s = {r_i, q_i[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, divisor_i};
        fits_s    = (shifted_s >= {1'b0, divisor_i});
        if (fits_s) begin
            r_o = diff_s[WIDTH-1:0];
        end else begin
            r_o = shifted_s[WIDTH-1:0];
        end
        q_o = {q_i[WIDTH-2:0], fits_s};
    end

endmodule

// File: rtl/seq_div.sv
// Iterative radix-2 restoring divider with start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds one FIX cycle).
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_r_s;
    logic [WIDTH-1:0] step_q_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    // Magnitudes of the operands; the most-negative value maps onto itself as unsigned.
    always_comb begin
        mag_a_s = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b_s = divisor[WIDTH-1]  ? -divisor  : divisor;
    end
`else
    // Unsigned build divides the operands as given.
    always_comb begin
        mag_a_s = dividend;
        mag_b_s = divisor;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (r_q),
        .q_i       (q_q),
        .divisor_i (dvs_q),
        .r_o       (step_r_s),
        .q_o       (step_q_s)
    );

    // Next-state logic; start wins in every state and aborts any running operation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        if (start) begin
            state_d = BUSY;
            count_d = '0;
            done_d  = 1'b0;
            dvs_d   = mag_b_s;
            dbz_d   = (divisor == '0);
`ifdef SIGNED_DIV_EN
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
                q_d = '1;
                r_d = dividend;
            end else begin
                q_d = mag_a_s;
                r_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                BUSY: begin
                    if (dbz_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        r_d     = step_r_s;
                        q_d     = step_q_s;
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
                            state_d = FIX;
`else
                            state_d = DONE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
`ifdef SIGNED_DIV_EN
                FIX: begin
                    q_d     = neg_quo_q ? -q_q : q_q;
                    r_d     = neg_rem_q ? -r_q : r_q;
                    state_d = DONE;
                    done_d  = 1'b1;
                end
`endif
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: stimulus pushes expectations, a monitor checks each done rise.
module tb_seq_div;

`ifdef SIGNED_DIV_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        start;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic done_prev = 1'b0;

    seq_div #(.WIDTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard head on every done rise.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (reset && done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", {16'd0, quotient}, {16'd0, e.q});
                    check("remainder", {16'd0, remainder}, {16'd0, e.r});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("latency", cyc - e.start_cyc, e.lat);
                end
            end
            done_prev = done;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                         input logic [15:0] er, input logic edbz, input int lat, input bit push);
        exp_t e;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.dbz = edbz; e.start_cyc = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("done_timeout", {31'd0, sb.size() != 0}, 32'd0);
        sb.delete();
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b, output logic [15:0] eq,
                         output logic [15:0] er, output logic edbz, output int lat);
        logic signed [15:0] sa;
        logic signed [15:0] sb_v;
        sa = a; sb_v = b;
        edbz = 1'b0;
        lat  = LAT;
        if (b == 16'd0) begin
            eq = 16'hFFFF; er = a; edbz = 1'b1; lat = 1;
`ifdef SIGNED_DIV_EN
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            eq = 16'h8000; er = 16'h0000;
        end else begin
            eq = sa / sb_v; er = sa % sb_v;
`else
        end else begin
            eq = a / b; er = a % b;
`endif
        end
    endtask

    initial begin
        logic [15:0] ra, rb, eq, er;
        logic        ed;
        int          lat;
        reset = 1'b0; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
        #12;
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        issue(16'd7, 16'd2, 16'h0003, 16'h0001, 1'b0, LAT, 1'b1);
        wait_idle();
        issue(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1, 1'b1);
        wait_idle();

        issue(16'd100, 16'd7, 16'h0, 16'h0, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clock);
        issue(16'd9, 16'd3, 16'h0003, 16'h0000, 1'b0, LAT, 1'b1);
        wait_idle();

        issue(16'd100, 16'd7, 16'h0, 16'h0, 1'b0, 0, 1'b0);
        repeat (7) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("midrst_quotient", {16'd0, quotient}, 32'd0);
        check("midrst_remainder", {16'd0, remainder}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        issue(16'hFFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, LAT, 1'b1);
        wait_idle();

`ifdef SIGNED_DIV_EN
        issue(16'hFFEC, 16'd3, 16'hFFFA, 16'hFFFE, 1'b0, 17, 1'b1);
        wait_idle();
        issue(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, 1'b1);
        wait_idle();
`else
        issue(16'hFFEC, 16'd3, 16'h554E, 16'h0002, 1'b0, 16, 1'b1);
        wait_idle();
        issue(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 16, 1'b1);
        wait_idle();
`endif

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = (i % 7 == 3) ? 16'd0 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            model(ra, rb, eq, er, ed, lat);
            issue(ra, rb, eq, er, ed, lat, 1'b1);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
